// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Central pipeline sequencer for the 5-stage core. Produces the
//             stall / flush / clear controls of the PC and of the IF/ID,
//             ID/EX, EX/MEM and MEM/WB registers from hazard, memory-wait and
//             branch-resolution inputs. Runs the post-reset pipeline clear,
//             squashes the stale fetch after a redirect and keeps saturating
//             stall / redirect performance counters.
//  Ports    : clk, rst (async, active-low)
//             D_rs1/D_rs2/D_use_rs1/D_use_rs2 : ID-stage source operands
//             E_rd/E_mem_read/E_mispredict/E_mdu_busy : EX-stage status
//             im_wait/dm_wait : instruction / data memory not ready
//             d_rst : active-low sync clear of all pipeline registers
//             pc_*, fd_*, de_*, em_*, mw_flush : per-register controls
//             stall_cycles, redirect_events : performance counters
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int INIT_CYCLES = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       D_rs1,
    input  logic [4:0]       D_rs2,
    input  logic             D_use_rs1,
    input  logic             D_use_rs2,
    input  logic [4:0]       E_rd,
    input  logic             E_mem_read,
    input  logic             E_mispredict,
    input  logic             E_mdu_busy,
    input  logic             im_wait,
    input  logic             dm_wait,
    output logic             d_rst,
    output logic             pc_stall,
    output logic             pc_redirect,
    output logic             fd_stall,
    output logic             fd_flush,
    output logic             de_stall,
    output logic             de_flush,
    output logic             em_stall,
    output logic             em_flush,
    output logic             mw_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_events
);

    localparam logic [1:0] c_ST_INIT   = 2'd0;
    localparam logic [1:0] c_ST_RUN    = 2'd1;
    localparam logic [1:0] c_ST_SQUASH = 2'd2;

    localparam int c_IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [c_IW-1:0]  r_init_cnt;
    logic             w_init_done;
    logic             w_load_use;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_redirect_events;

    assign w_init_done = (r_init_cnt == c_IW'(INIT_CYCLES - 1));

    assign w_load_use = E_mem_read && (E_rd != 5'd0) &&
                        ((D_use_rs1 && (D_rs1 == E_rd)) ||
                         (D_use_rs2 && (D_rs2 == E_rd)));

    // Mealy decode: outputs react to inputs in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        d_rst       = 1'b1;
        pc_stall    = 1'b0;
        pc_redirect = 1'b0;
        fd_stall    = 1'b0;
        fd_flush    = 1'b0;
        de_stall    = 1'b0;
        de_flush    = 1'b0;
        em_stall    = 1'b0;
        em_flush    = 1'b0;
        mw_flush    = 1'b0;

        if (r_state == c_ST_INIT) begin
            d_rst    = 1'b0;
            pc_stall = 1'b1;
            if (w_init_done) begin
                w_state_nxt = c_ST_RUN;
            end
        end else if (dm_wait) begin
            // Whole front of the pipe freezes; bubble into WB.
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            de_stall = 1'b1;
            em_stall = 1'b1;
            mw_flush = 1'b1;
        end else if (E_mdu_busy) begin
            // EX holds the mul/div; bubble into MEM.
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            de_stall = 1'b1;
            em_flush = 1'b1;
        end else if (r_state == c_ST_SQUASH) begin
            // Discard the wrong-path fetch still in flight; leave once it lands.
            pc_stall = 1'b1;
            fd_flush = 1'b1;
            if (!im_wait) begin
                w_state_nxt = c_ST_RUN;
            end
        end else if (E_mispredict) begin
            pc_redirect = 1'b1;
            fd_flush    = 1'b1;
            de_flush    = 1'b1;
            // An outstanding fetch is from the wrong path and must be squashed.
            if (im_wait) begin
                w_state_nxt = c_ST_SQUASH;
            end
        end else if (w_load_use) begin
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            de_flush = 1'b1;
        end else if (im_wait) begin
            pc_stall = 1'b1;
            fd_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state           <= c_ST_INIT;
            r_init_cnt        <= '0;
            r_stall_cycles    <= '0;
            r_redirect_events <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_ST_INIT) begin
                r_init_cnt <= w_init_done ? '0 : r_init_cnt + 1'b1;
            end
            if ((r_state != c_ST_INIT) && pc_stall && !(&r_stall_cycles)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (pc_redirect && !(&r_redirect_events)) begin
                r_redirect_events <= r_redirect_events + 1'b1;
            end
        end
    end

    assign stall_cycles    = r_stall_cycles;
    assign redirect_events = r_redirect_events;

endmodule
`default_nettype wire
